// File: rtl/slot_release_exit.sv
// Exit-side slot release: validates the exiting flat against the shared occupancy
// vector, hands a clear request to the table owner, then times the exit barrier.
module slot_release_exit #(
  parameter int N           = 8,
  parameter int GATE_CYCLES = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 exit_req,
  input  logic [$clog2(N):0]   exit_flat,
  input  logic [N:0]           occ_vec,
  output logic                 clr_valid,
  output logic [$clog2(N):0]   clr_idx,
  input  logic                 clr_ack,
  output logic                 busy,
  output logic                 exit_done,
  output logic                 exit_err,
  output logic [1:0]           err_code,
  output logic                 gate_open,
  output logic [$clog2(N):0]   free_count
);

  localparam int W    = $clog2(N) + 1;
  localparam int TMAX = (GATE_CYCLES > ACK_TIMEOUT) ? GATE_CYCLES : ACK_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [W-1:0]  IDX_MAX   = W'(N);
  localparam logic [W-1:0]  CNT_ONE   = W'(1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
  localparam logic [TW-1:0] GATE_LOAD = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LOAD  = TW'(ACK_TIMEOUT - 1);
  localparam logic [N:0]    SLOT_ONE  = (N+1)'(1);
  localparam logic [1:0]    ERR_FLAT  = 2'b01;
  localparam logic [1:0]    ERR_EMPTY = 2'b10;
  localparam logic [1:0]    ERR_TMO   = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_CLEAR, S_GATE, S_DENY} state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_clr_idx, w_clr_idx_nxt;
  logic            r_clr_valid, w_clr_valid_nxt;
  logic            r_exit_done, w_exit_done_nxt;
  logic            r_exit_err, w_exit_err_nxt;
  logic [1:0]      r_err_code, w_err_code_nxt;
  logic            r_gate_open, w_gate_open_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [W-1:0]    r_free_count, w_free;
  logic            w_idx_bad, w_slot_occ;

  // Mask-based select keeps out-of-range indices harmless; they are rejected anyway.
  assign w_idx_bad  = (r_clr_idx == '0) || (r_clr_idx > IDX_MAX);
  assign w_slot_occ = |(occ_vec & (SLOT_ONE << r_clr_idx));

  always_comb begin
    w_free = '0;
    for (int k = 1; k <= N; k++) begin
      if (!occ_vec[k]) w_free = w_free + CNT_ONE;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_clr_idx_nxt   = r_clr_idx;
    w_clr_valid_nxt = 1'b0;
    w_exit_done_nxt = 1'b0;
    w_exit_err_nxt  = 1'b0;
    w_err_code_nxt  = 2'b00;
    w_gate_open_nxt = 1'b0;
    w_timer_nxt     = r_timer;
    case (r_state)
      S_IDLE: begin
        if (exit_req) begin
          w_clr_idx_nxt = exit_flat;
          w_state_nxt   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_idx_bad) begin
          w_state_nxt    = S_DENY;
          w_exit_err_nxt = 1'b1;
          w_err_code_nxt = ERR_FLAT;
        end else if (!w_slot_occ) begin
          w_state_nxt    = S_DENY;
          w_exit_err_nxt = 1'b1;
          w_err_code_nxt = ERR_EMPTY;
        end else begin
          w_state_nxt     = S_CLEAR;
          w_clr_valid_nxt = 1'b1;
          w_timer_nxt     = ACK_LOAD;
        end
      end
      S_CLEAR: begin
        // Ack is checked first so it wins over a timeout in the same cycle.
        if (clr_ack) begin
          w_state_nxt     = S_GATE;
          w_exit_done_nxt = 1'b1;
          w_gate_open_nxt = 1'b1;
          w_timer_nxt     = GATE_LOAD;
        end else if (r_timer == '0) begin
          w_state_nxt    = S_DENY;
          w_exit_err_nxt = 1'b1;
          w_err_code_nxt = ERR_TMO;
        end else begin
          w_clr_valid_nxt = 1'b1;
          w_timer_nxt     = r_timer - TMR_ONE;
        end
      end
      S_GATE: begin
        if (r_timer == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gate_open_nxt = 1'b1;
          w_timer_nxt     = r_timer - TMR_ONE;
        end
      end
      S_DENY:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_clr_idx    <= '0;
      r_clr_valid  <= 1'b0;
      r_exit_done  <= 1'b0;
      r_exit_err   <= 1'b0;
      r_err_code   <= 2'b00;
      r_gate_open  <= 1'b0;
      r_timer      <= '0;
      r_free_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_idx    <= w_clr_idx_nxt;
      r_clr_valid  <= w_clr_valid_nxt;
      r_exit_done  <= w_exit_done_nxt;
      r_exit_err   <= w_exit_err_nxt;
      r_err_code   <= w_err_code_nxt;
      r_gate_open  <= w_gate_open_nxt;
      r_timer      <= w_timer_nxt;
      r_free_count <= w_free;
    end
  end

  assign clr_valid  = r_clr_valid;
  assign clr_idx    = r_clr_idx;
  assign busy       = (r_state != S_IDLE);
  assign exit_done  = r_exit_done;
  assign exit_err   = r_exit_err;
  assign err_code   = r_err_code;
  assign gate_open  = r_gate_open;
  assign free_count = r_free_count;

endmodule

// File: doc/slot_release_exit.md
Name: slot_release_exit

Overview:
Exit-side counterpart of the entry slot-availability check. It accepts an exit request carrying a flat number and checks that flat's slot in the shared occupancy vector. For an occupied slot it issues a clear handshake to the occupancy-table owner, then holds the exit gate open for a fixed time. It sits between the exit keypad/tag reader and the occupancy table that the entry path also writes.

Parameters:
N, 8, number of parking slots; one slot per flat, flats numbered 1..N (index 0 unused)
GATE_CYCLES, 16, clock cycles gate_open stays high after a successful release (>=1)
ACK_TIMEOUT, 8, max cycles to wait for clr_ack before aborting (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
exit_req  input  1  exit request strobe; sampled only in IDLE
exit_flat  input  $clog2(N)+1  flat number of exiting vehicle, sampled with exit_req
occ_vec  input  N+1  current occupancy, bit k = 1 means slot k occupied; bit 0 ignored
clr_valid  output  1  request to table owner to clear slot clr_idx
clr_idx  output  $clog2(N)+1  slot to clear; stable while clr_valid=1
clr_ack  input  1  table owner has cleared slot; honoured only while clr_valid=1
busy  output  1  high in any state other than IDLE
exit_done  output  1  one-cycle pulse: release succeeded
exit_err  output  1  one-cycle pulse: request rejected or aborted
err_code  output  2  valid with exit_err: 01 invalid flat, 10 slot already empty, 11 ack timeout
gate_open  output  1  exit barrier drive
free_count  output  $clog2(N)+1  registered count of zero bits in occ_vec[N:1], updated every cycle

Behaviour:
- Reset (async assert, sync-released use): state=IDLE; clr_valid, busy, exit_done, exit_err, gate_open = 0; clr_idx, err_code = 0; free_count = 0 (first valid value 1 cycle after release); timers = 0.
- FSM states: IDLE, CHECK, CLEAR, GATE, DENY.
- IDLE: when exit_req=1, latch exit_flat into clr_idx and go to CHECK. exit_req in any other state is ignored and not queued.
- CHECK (1 cycle): evaluate occ_vec with the latched index.
  - index==0 or index>N -> DENY, code 01.
  - occ_vec[index]==0 -> DENY, code 10.
  - otherwise -> CLEAR, with clr_valid=1 from the next cycle.
- CLEAR: hold clr_valid=1 and clr_idx stable.
  - clr_ack=1 -> clr_valid=0 next cycle; exit_done pulses for 1 cycle; go to GATE; load gate timer.
  - No ack after ACK_TIMEOUT cycles in CLEAR -> drop clr_valid; go to DENY, code 11. The gate never opens.
  - Ack and timeout in the same cycle: the ack wins.
- GATE: gate_open=1 for exactly GATE_CYCLES cycles, then IDLE. The timer counts down and does not wrap.
- DENY: exit_err=1 and err_code valid for exactly 1 cycle, then IDLE. err_code returns to 00 afterwards.
- Latency:
  - exit_req in cycle t -> CHECK at t+1, clr_valid rises at t+2.
  - Ack at cycle a -> exit_done and gate_open rise at a+1.
  - Rejection -> exit_err at t+2.
- busy=1 in CHECK, CLEAR, GATE and DENY.
- clr_ack outside CLEAR is ignored.
- occ_vec changes are only sampled in CHECK. An entry-side write during CLEAR does not affect this transaction.
- Reset mid-operation: everything returns to reset values immediately, including gate_open=0 and clr_valid=0. A pending clear is abandoned; no pulse is emitted.
- free_count counts slots 1..N only. Range is 0..N; no overflow at N.

Test Plan:
- N=8, occ_vec=9'b0_0010_0100, exit_req with flat 5, clr_ack 2 cycles after clr_valid -> clr_valid with clr_idx=5; exit_done 1 pulse; gate_open high exactly 16 cycles; busy low after.
- Flat 3 while occ_vec[3]=0 -> exit_err at t+2, err_code=10, no clr_valid, gate stays 0.
- Flats 0 and 9 -> each gives exit_err with err_code=01 and no clr_valid.
- Occupied flat 7, clr_ack never asserted -> clr_valid high exactly 8 cycles, then exit_err with err_code=11, gate_open=0.
- exit_req pulsed repeatedly during GATE plus stray clr_ack in IDLE -> no extra transactions, no extra pulses.
- rst_n low mid-GATE (cycle 5) and mid-CLEAR -> gate_open and clr_valid drop asynchronously; after release, IDLE, busy=0.
- free_count: occ_vec all ones, then all zeros, then 9'b1_0000_0001 -> free_count 0, then 8, then 7 (each one cycle later).
